button_toggle_pulse: RTL and testbench



---
 rtl/digital_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/button_toggle_pulse.sv | 111 +++++++++++
 tb/tb_button_toggle_pulse.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/digital_pkg.sv
// digital_pkg: shared types and helpers for the user-input blocks.
package digital_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      REPEAT,
      RELEASE_WAIT
   } btn_state_t;

   // Bits needed to count 0..max(a,b,c)-1 (never less than 1).
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser with synchronous active-high reset.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q, sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/button_toggle_pulse.sv
// button_toggle_pulse: debounced push-button to one-cycle toggle strobe,
// with optional auto-repeat while the button is held.
module button_toggle_pulse
   import digital_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter bit REPEAT_EN       = 1'b1,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_PERIOD   = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   input  logic enable,
   output logic t_pulse,
   output logic pressed
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DLY_MAX = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_MAX = CW'(REPEAT_PERIOD - 1);

   logic       btn_s;
   btn_state_t state_q;
   logic [CW-1:0] cnt_q;
   logic       t_pulse_q, pressed_q;

   sync_2ff #(.W(1)) u_sync (
      .clk  (clk),
      .reset(reset),
      .d_i  (btn_in),
      .q_o  (btn_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         t_pulse_q <= 1'b0;
         pressed_q <= 1'b0;
      end else begin
         t_pulse_q <= 1'b0;
         case (state_q)
            IDLE: begin
               pressed_q <= 1'b0;
               cnt_q     <= '0;
               if (btn_s) state_q <= PRESS_WAIT;
            end
            PRESS_WAIT: begin
               if (!btn_s) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == DEB_MAX) begin
                  state_q   <= HELD;
                  cnt_q     <= '0;
                  pressed_q <= 1'b1;
                  t_pulse_q <= enable;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HELD: begin
               if (!btn_s) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= '0;
               end else if (REPEAT_EN && cnt_q == DLY_MAX) begin
                  state_q   <= REPEAT;
                  cnt_q     <= '0;
                  t_pulse_q <= enable;
               end else if (REPEAT_EN || cnt_q != '1) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            REPEAT: begin
               if (!btn_s) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= '0;
               end else if (cnt_q == PER_MAX) begin
                  cnt_q     <= '0;
                  t_pulse_q <= enable;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RELEASE_WAIT: begin
               // A bounce back high returns to HELD, restarting the repeat delay.
               if (btn_s) begin
                  state_q <= HELD;
                  cnt_q   <= '0;
               end else if (cnt_q == DEB_MAX) begin
                  state_q   <= IDLE;
                  cnt_q     <= '0;
                  pressed_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q   <= IDLE;
               cnt_q     <= '0;
               pressed_q <= 1'b0;
            end
         endcase
      end
   end

   assign t_pulse = t_pulse_q;
   assign pressed = pressed_q;

endmodule

// File: tb/tb_button_toggle_pulse.sv
// tb_button_toggle_pulse: directed scoreboard bench for a no-repeat and a repeat instance.
module tb_button_toggle_pulse;

   logic clk = 1'b0;
   logic reset, btn_in, enable;
   logic tp_n, pr_n, tp_r, pr_r;
   logic prev_n, prev_r;
   int   e, total, bad;
   int   qn[$];
   int   qr[$];

   always #5 clk = ~clk;

   button_toggle_pulse #(
      .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
   ) u_norep (
      .clk(clk), .reset(reset), .btn_in(btn_in), .enable(enable),
      .t_pulse(tp_n), .pressed(pr_n)
   );

   button_toggle_pulse #(
      .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
   ) u_rep (
      .clk(clk), .reset(reset), .btn_in(btn_in), .enable(enable),
      .t_pulse(tp_r), .pressed(pr_r)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge, pulses matched against the queues.
   task automatic step();
      @(posedge clk);
      #1;
      e++;
      if (tp_n) begin
         if (qn.size() == 0) chk("norep_extra_pulse", e, -1);
         else chk("norep_pulse_edge", e, qn.pop_front());
         if (prev_n) chk("norep_back_to_back", 1, 0);
      end
      if (tp_r) begin
         if (qr.size() == 0) chk("rep_extra_pulse", e, -1);
         else chk("rep_pulse_edge", e, qr.pop_front());
         if (prev_r) chk("rep_back_to_back", 1, 0);
      end
      prev_n = tp_n;
      prev_r = tp_r;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      btn_in = 1'b0;
      enable = 1'b1;
      e      = -100;
      repeat (3) step();
      chk("rst_tp_n", tp_n, 0);
      chk("rst_pr_n", pr_n, 0);
      chk("rst_tp_r", tp_r, 0);
      chk("rst_pr_r", pr_r, 0);
      reset = 1'b0;
      e     = -1;
   endtask

   task automatic end_test(input string tag);
      chk({tag, "_norep_missing"}, qn.size(), 0);
      chk({tag, "_rep_missing"}, qr.size(), 0);
      qn.delete();
      qr.delete();
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      prev_n = 1'b0;
      prev_r = 1'b0;

      // Long press and release.
      do_reset();
      qn = {6};
      qr = {6, 14, 18, 22, 26, 30, 34, 38};
      btn_in = 1'b1;
      while (e < 39) begin
         step();
         if (e == 5) chk("t1_pr_before", pr_n, 0);
         if (e == 6) begin
            chk("t1_pr_n_rise", pr_n, 1);
            chk("t1_pr_r_rise", pr_r, 1);
         end
      end
      btn_in = 1'b0;
      while (e < 46) begin
         step();
         if (e == 45) chk("t1_pr_still", pr_n, 1);
      end
      chk("t1_pr_n_fall", pr_n, 0);
      chk("t1_pr_r_fall", pr_r, 0);
      end_test("t1");

      // Bounce shorter than the debounce window.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         btn_in = 1'b1;
         repeat (3) step();
         btn_in = 1'b0;
         repeat (2) step();
         chk("t2_pr_n", pr_n, 0);
         chk("t2_pr_r", pr_r, 0);
      end
      repeat (8) step();
      chk("t2_pr_n_end", pr_n, 0);
      chk("t2_pr_r_end", pr_r, 0);
      end_test("t2");

      // Two-cycle low glitch while held restarts the repeat delay.
      do_reset();
      qn = {6};
      qr = {6, 21, 25, 29};
      btn_in = 1'b1;
      while (e < 8) step();
      chk("t3_pr_held", pr_r, 1);
      btn_in = 1'b0;
      step();
      step();
      btn_in = 1'b1;
      while (e < 30) begin
         step();
         chk("t3_pr_n", pr_n, 1);
         chk("t3_pr_r", pr_r, 1);
      end
      end_test("t3");

      // Press edge masked by enable; later repeats pass.
      do_reset();
      enable = 1'b0;
      qr = {14, 18, 22};
      btn_in = 1'b1;
      while (e < 6) step();
      chk("t4_tp_masked", tp_r, 0);
      chk("t4_pr_r", pr_r, 1);
      enable = 1'b1;
      while (e < 24) step();
      end_test("t4");

      // Reset mid-repeat with the button still held.
      do_reset();
      qn = {6, 29};
      qr = {6, 14, 18, 29};
      btn_in = 1'b1;
      while (e < 21) step();
      reset = 1'b1;
      step();
      chk("t5_tp_n_rst", tp_n, 0);
      chk("t5_pr_n_rst", pr_n, 0);
      chk("t5_tp_r_rst", tp_r, 0);
      chk("t5_pr_r_rst", pr_r, 0);
      reset = 1'b0;
      while (e < 28) step();
      chk("t5_pr_r_pre", pr_r, 0);
      while (e < 32) step();
      chk("t5_pr_n_again", pr_n, 1);
      chk("t5_pr_r_again", pr_r, 1);
      end_test("t5");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
